// File: rtl/fdiv_result_packer_if.sv
// Handshake bundle between the mantissa divider side and the packed FP32 consumer.
// Carries the input operands with their divider results, plus the output result stream.
// The slave modport belongs to the packer; the master modport belongs to whoever drives it.
interface fdiv_result_packer_if #(
    parameter int BIT_WIDTH = 23,
    parameter int EXP_WIDTH = 8
);
    localparam int W = 1 + EXP_WIDTH + BIT_WIDTH;

    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in0;
    logic [W-1:0]         in1;
    logic [BIT_WIDTH-1:0] mant_q;
    logic                 carry_down;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out;

    modport slave (
        input  in_valid, in0, in1, mant_q, carry_down, out_ready,
        output in_ready, out_valid, out
    );

    modport master (
        output in_valid, in0, in1, mant_q, carry_down, out_ready,
        input  in_ready, out_valid, out
    );
endinterface

// File: rtl/fdiv_result_packer.sv
// FP32 divide back end: sign/exponent, IEEE special cases, overflow/underflow saturation, packing.
// Latency 2 cycles (S1 exponent/class, S2 pack register), throughput 1 result per cycle.
// Backpressure: out_ready low holds out; S1+S2 buffer two results, then in_ready drops.
// Optional macro FDIV_STATUS_EN adds sticky {invalid, div_zero, overflow, underflow} status.
module fdiv_result_packer #(
    parameter int BIT_WIDTH = 23,
    parameter int EXP_WIDTH = 8,
    parameter int BIAS      = 127
) (
    input  logic                clk,
    input  logic                rst_n,
    fdiv_result_packer_if.slave bus
`ifdef FDIV_STATUS_EN
    ,
    input  logic                status_clr,
    output logic [3:0]          status
`endif
);
    localparam int W   = 1 + EXP_WIDTH + BIT_WIDTH;
    localparam int EW2 = EXP_WIDTH + 2;
    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

    // ---------------- handshake ----------------
    logic w_s1_adv;
    logic w_s2_adv;
    logic r_s1_valid;
    logic r_out_valid;

    assign w_s2_adv     = ~r_out_valid | bus.out_ready;
    assign w_s1_adv     = ~r_s1_valid | w_s2_adv;
    assign bus.in_ready = w_s1_adv;

    // ---------------- S1 combinational: fields, class, exponent ----------------
    logic [EXP_WIDTH-1:0] w_e0, w_e1;
    logic [BIT_WIDTH-1:0] w_f0, w_f1;
    logic [EW2-1:0]       w_exp;

    assign w_e0 = bus.in0[W-2 -: EXP_WIDTH];
    assign w_e1 = bus.in1[W-2 -: EXP_WIDTH];
    assign w_f0 = bus.in0[BIT_WIDTH-1:0];
    assign w_f1 = bus.in1[BIT_WIDTH-1:0];

    // Two's complement in EXP_WIDTH+2 bits; the MSB is the sign of the biased exponent.
    assign w_exp = EW2'(w_e0) - EW2'(w_e1) + EW2'(BIAS) - EW2'(bus.carry_down);

    logic                 r_s1_sign;
    logic [EW2-1:0]       r_s1_exp;
    logic [BIT_WIDTH-1:0] r_s1_mant;
    logic                 r_s1_a_zero, r_s1_a_inf, r_s1_a_nan;
    logic                 r_s1_b_zero, r_s1_b_inf, r_s1_b_nan;

    // S1 register: capture sign, exponent and operand class; denormals classify as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_mant   <= '0;
            r_s1_a_zero <= 1'b0;
            r_s1_a_inf  <= 1'b0;
            r_s1_a_nan  <= 1'b0;
            r_s1_b_zero <= 1'b0;
            r_s1_b_inf  <= 1'b0;
            r_s1_b_nan  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign   <= bus.in0[W-1] ^ bus.in1[W-1];
                r_s1_exp    <= w_exp;
                r_s1_mant   <= bus.mant_q;
                r_s1_a_zero <= (w_e0 == '0);
                r_s1_a_inf  <= (w_e0 == EXP_ONES) && (w_f0 == '0);
                r_s1_a_nan  <= (w_e0 == EXP_ONES) && (w_f0 != '0);
                r_s1_b_zero <= (w_e1 == '0);
                r_s1_b_inf  <= (w_e1 == EXP_ONES) && (w_f1 == '0);
                r_s1_b_nan  <= (w_e1 == EXP_ONES) && (w_f1 != '0);
            end
        end
    end

    // ---------------- S2 combinational: resolve result ----------------
    logic         w_ovf, w_unf;
    logic [W-1:0] w_pack;
    logic [3:0]   w_flags;  // {invalid, div_zero, overflow, underflow}

    assign w_ovf = ~r_s1_exp[EW2-1] && (r_s1_exp[EW2-2:0] >= {1'b0, EXP_ONES});
    assign w_unf =  r_s1_exp[EW2-1] || (r_s1_exp == '0);

    // Priority chain: earlier special cases override the arithmetic exponent.
    always_comb begin
        w_pack  = {r_s1_sign, r_s1_exp[EXP_WIDTH-1:0], r_s1_mant};
        w_flags = 4'b0000;
        if (r_s1_a_nan || r_s1_b_nan || (r_s1_a_zero && r_s1_b_zero) ||
            (r_s1_a_inf && r_s1_b_inf)) begin
            w_pack  = {1'b0, EXP_ONES, 1'b1, {(BIT_WIDTH-1){1'b0}}};
            w_flags = 4'b1000;
        end else if (r_s1_b_zero) begin
            w_pack  = {r_s1_sign, EXP_ONES, {BIT_WIDTH{1'b0}}};
            w_flags = 4'b0100;
        end else if (r_s1_a_inf) begin
            w_pack  = {r_s1_sign, EXP_ONES, {BIT_WIDTH{1'b0}}};
        end else if (r_s1_a_zero || r_s1_b_inf) begin
            w_pack  = {r_s1_sign, {(W-1){1'b0}}};
        end else if (w_ovf) begin
            w_pack  = {r_s1_sign, EXP_ONES, {BIT_WIDTH{1'b0}}};
            w_flags = 4'b0010;
        end else if (w_unf) begin
            w_pack  = {r_s1_sign, {(W-1){1'b0}}};
            w_flags = 4'b0001;
        end
    end

    logic [W-1:0] r_out;

`ifdef FDIV_STATUS_EN
    logic [3:0] r_out_flags;
    logic [3:0] r_status;
`endif

    // S2 register: output result and valid, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
`ifdef FDIV_STATUS_EN
            r_out_flags <= 4'b0000;
`endif
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= w_pack;
`ifdef FDIV_STATUS_EN
                r_out_flags <= w_flags;
`endif
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;

`ifdef FDIV_STATUS_EN
    // Sticky status: bits set on output transfer; a same-cycle clear loses to the set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= 4'b0000;
        end else begin
            r_status <= (status_clr ? 4'b0000 : r_status) |
                        ((r_out_valid && bus.out_ready) ? r_out_flags : 4'b0000);
        end
    end

    assign status = r_status;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^w_flags;
`endif
endmodule
